// File: rtl/rgb2ycbcr_if.sv
// rgb2ycbcr_if: pixel, sideband and mode signals into and out of the colour converter.
interface rgb2ycbcr_if #(parameter int COLORDEPTH = 8);
    logic [COLORDEPTH-1:0] red_i, green_i, blue_i;
    logic dv_i, hs_i, vs_i;
    logic [1:0] mode_i;
    logic [COLORDEPTH-1:0] ch0_o, ch1_o, ch2_o;
    logic dv_o, hs_o, vs_o, line_end_o;
    logic [1:0] mode_active_o;
    modport master (
        output red_i, green_i, blue_i, dv_i, hs_i, vs_i, mode_i,
        input ch0_o, ch1_o, ch2_o, dv_o, hs_o, vs_o, line_end_o, mode_active_o
    );
    modport slave (
        input red_i, green_i, blue_i, dv_i, hs_i, vs_i, mode_i,
        output ch0_o, ch1_o, ch2_o, dv_o, hs_o, vs_o, line_end_o, mode_active_o
    );
endinterface

// File: rtl/rgb2ycbcr.sv
// rgb2ycbcr: 3-stage RGB to bypass/gray/YCbCr converter with per-frame mode latch.
// Stage 1 products, stage 2 rounded sums, stage 3 shift/offset/clamp/select.
module rgb2ycbcr #(
    parameter int COLORDEPTH = 8,
    parameter bit SYNC_ACTIVE_HIGH = 1
) (
    input logic clk,
    input logic rst,
    rgb2ycbcr_if.slave bus
);
    localparam int CD = COLORDEPTH;
    localparam int AW = CD + 10;
    localparam logic signed [AW-1:0] HALF = AW'(2 ** (CD - 1));
    localparam logic signed [AW-1:0] MAXV = AW'(2 ** CD - 1);
    localparam logic signed [AW-1:0] RND = AW'(128);
    logic vs_act, vs_prev, fs, dv_prev, gy;
    logic [1:0] mode_reg, mode_cur, m1, m2;
    logic [2:0] sb1, sb2;
    logic [3*CD-1:0] rgb1, rgb2;
    logic signed [AW-1:0] rs, gs, bs, sy, scb, scr, cb_full, cr_full;
    logic signed [AW-1:0] p [9];
    logic [CD-1:0] y, cb, cr, n0, n1, n2;
    assign vs_act = SYNC_ACTIVE_HIGH ? bus.vs_i : ~bus.vs_i;
    assign fs = vs_act & ~vs_prev;
    // a frame-start pixel already uses the newly requested mode
    assign mode_cur = fs ? bus.mode_i : mode_reg;
    assign rs = $signed({10'b0, bus.red_i});
    assign gs = $signed({10'b0, bus.green_i});
    assign bs = $signed({10'b0, bus.blue_i});
    assign bus.line_end_o = dv_prev & ~bus.dv_o;
    always_comb begin
        y = CD'(sy >>> 8);
        cb_full = (scb >>> 8) + HALF;
        cr_full = (scr >>> 8) + HALF;
        cb = cb_full < 0 ? '0 : cb_full > MAXV ? '1 : CD'(cb_full);
        cr = cr_full < 0 ? '0 : cr_full > MAXV ? '1 : CD'(cr_full);
        gy = (m2 == 2'd1) || (m2 == 2'd2);
        n0 = !sb2[2] ? '0 : gy ? y : rgb2[3*CD-1:2*CD];
        n1 = !sb2[2] ? '0 : m2 == 2'd2 ? cb : gy ? y : rgb2[2*CD-1:CD];
        n2 = !sb2[2] ? '0 : m2 == 2'd2 ? cr : gy ? y : rgb2[CD-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_prev <= 1'b0;
            mode_reg <= 2'd0;
            m1 <= 2'd0;
            m2 <= 2'd0;
            sb1 <= '0;
            sb2 <= '0;
            rgb1 <= '0;
            rgb2 <= '0;
            for (int i = 0; i < 9; i++) p[i] <= '0;
            sy <= '0;
            scb <= '0;
            scr <= '0;
            dv_prev <= 1'b0;
            bus.ch0_o <= '0;
            bus.ch1_o <= '0;
            bus.ch2_o <= '0;
            bus.dv_o <= 1'b0;
            bus.hs_o <= 1'b0;
            bus.vs_o <= 1'b0;
            bus.mode_active_o <= 2'd0;
        end else begin
            vs_prev <= vs_act;
            mode_reg <= mode_cur;
            m1 <= mode_cur;
            sb1 <= {bus.dv_i, bus.hs_i, bus.vs_i};
            rgb1 <= {bus.red_i, bus.green_i, bus.blue_i};
            p[0] <= AW'(77) * rs;
            p[1] <= AW'(150) * gs;
            p[2] <= AW'(29) * bs;
            p[3] <= AW'(-43) * rs;
            p[4] <= AW'(-85) * gs;
            p[5] <= AW'(128) * bs;
            p[6] <= AW'(128) * rs;
            p[7] <= AW'(-107) * gs;
            p[8] <= AW'(-21) * bs;
            m2 <= m1;
            sb2 <= sb1;
            rgb2 <= rgb1;
            sy <= p[0] + p[1] + p[2] + RND;
            scb <= p[3] + p[4] + p[5] + RND;
            scr <= p[6] + p[7] + p[8] + RND;
            bus.ch0_o <= n0;
            bus.ch1_o <= n1;
            bus.ch2_o <= n2;
            {bus.dv_o, bus.hs_o, bus.vs_o} <= sb2;
            bus.mode_active_o <= m2;
            dv_prev <= bus.dv_o;
        end
    end
endmodule
